// File: rtl/fc_flatten_pkg.sv
// fc_flatten_pkg: shared types and default geometry for the flatten transmitter.
//   state_t        : transmit-side FSM states
//   DEF_CHANNELS   : default feature-map channel count
//   DEF_HEIGHT     : default feature-map rows
//   DEF_WIDTH      : default feature-map columns
//   bits_for()     : address/counter width for a range of n values (minimum 1)
package fc_flatten_pkg;

  localparam int unsigned DEF_CHANNELS = 16;
  localparam int unsigned DEF_HEIGHT   = 5;
  localparam int unsigned DEF_WIDTH    = 5;

  typedef enum logic [1:0] {
    CAPTURE   = 2'd0,
    WAIT_SINK = 2'd1,
    SEND      = 2'd2
  } state_t;

  function automatic int unsigned bits_for(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fc_flatten_ram.sv
// fc_flatten_ram: simple dual-port RAM, one write port and one registered read
// port, 8-bit signed words. No reset on storage or read register so it maps
// onto block RAM.
//   clk        in  : clock
//   i_wr_en    in  : write strobe
//   i_wr_addr  in  : write address
//   i_wr_data  in  : write data
//   i_rd_en    in  : read strobe (updates o_rd_data next cycle)
//   i_rd_addr  in  : read address
//   o_rd_data  out : read data, one cycle after i_rd_en
module fc_flatten_ram #(
  parameter int unsigned DEPTH = 400,
  parameter int unsigned AW    = 9
) (
  input  logic                clk,
  input  logic                i_wr_en,
  input  logic [AW-1:0]       i_wr_addr,
  input  logic signed [7:0]   i_wr_data,
  input  logic                i_rd_en,
  input  logic [AW-1:0]       i_rd_addr,
  output logic signed [7:0]   o_rd_data
);

  logic signed [7:0] r_mem [DEPTH];
  logic signed [7:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fc_flatten_tx.sv
// fc_flatten_tx: captures a feature map arriving pixel-major (row, col, channel
// fastest) and replays it channel-major as one contiguous N-byte burst,
// N = CHANNELS*HEIGHT*WIDTH.
// Optional build macro FC_FLATTEN_DBUF_EN: ping-pong buffering, so capture of
// the next frame continues while the previous one waits for / streams to the sink.
//   clk              in  : clock, rising edge
//   rst              in  : synchronous active-high reset
//   i_pix_in         in  : feature pixel
//   i_pix_valid_in   in  : i_pix_in valid
//   i_sink_ready     in  : sink can take a full burst
//   o_data_out       out : flattened byte, 0 when not valid
//   o_data_valid_out out : o_data_out valid
//   o_frame_sent     out : pulse on the cycle after the last byte of a burst
//   o_overflow       out : sticky, a pixel was dropped
//
// state     | meaning
// CAPTURE   | no frame pending; filling the capture buffer
// WAIT_SINK | a full frame is pending; waiting for i_sink_ready
// SEND      | streaming the pending frame, one read per cycle
module fc_flatten_tx
  import fc_flatten_pkg::*;
#(
  parameter int unsigned CHANNELS = DEF_CHANNELS,
  parameter int unsigned HEIGHT   = DEF_HEIGHT,
  parameter int unsigned WIDTH    = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [7:0]  i_pix_in,
  input  logic               i_pix_valid_in,
  input  logic               i_sink_ready,
  output logic signed [7:0]  o_data_out,
  output logic               o_data_valid_out,
  output logic               o_frame_sent,
  output logic               o_overflow
);

  localparam int unsigned HW = HEIGHT * WIDTH;
  localparam int unsigned N  = CHANNELS * HW;
  localparam int unsigned AW = bits_for(N);
  localparam int unsigned CW = bits_for(CHANNELS);
  localparam int unsigned XW = bits_for(WIDTH);
  localparam int unsigned YW = bits_for(HEIGHT);
`ifdef FC_FLATTEN_DBUF_EN
  localparam int unsigned DEPTH = 2 * N;
`else
  localparam int unsigned DEPTH = N;
`endif
  localparam int unsigned RW = bits_for(DEPTH);

  state_t r_state, w_next_state;

  logic [CW-1:0] r_c;
  logic [XW-1:0] r_col;
  logic [YW-1:0] r_row;
  logic [AW-1:0] r_pos;      // r*WIDTH + col, kept incrementally
  logic [AW-1:0] r_wr_addr;  // c*HW + r_pos, kept incrementally
  logic [AW-1:0] r_rd_addr;

  logic r_ram_valid, r_ram_last;
  logic signed [7:0] r_data_out;
  logic r_data_valid_out, r_out_last, r_frame_sent, r_overflow;

  logic w_can_write, w_accept, w_frame_done, w_send_last, w_pending;
  logic [RW-1:0] w_ram_wr_addr, w_ram_rd_addr;
  logic signed [7:0] w_ram_rd_data;

  assign w_accept     = i_pix_valid_in && w_can_write;
  assign w_frame_done = w_accept && (r_c == CW'(CHANNELS - 1))
                        && (r_col == XW'(WIDTH - 1)) && (r_row == YW'(HEIGHT - 1));
  assign w_send_last  = (r_state == SEND) && (r_rd_addr == AW'(N - 1));

`ifdef FC_FLATTEN_DBUF_EN
  logic [1:0] r_full;
  logic       r_wr_bank, r_rd_bank;

  assign w_can_write   = !r_full[r_wr_bank];
  // Next frame ready behind the one finishing: either already full, or
  // completing on the very edge the burst ends.
  assign w_pending     = r_full[~r_rd_bank] || w_frame_done;
  assign w_ram_wr_addr = RW'(r_wr_addr) + (r_wr_bank ? RW'(N) : RW'(0));
  assign w_ram_rd_addr = RW'(r_rd_addr) + (r_rd_bank ? RW'(N) : RW'(0));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full    <= 2'b00;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
    end else begin
      // A completing write bank is never the bank being read, so the set and
      // clear below never hit the same flag.
      if (w_frame_done) begin
        r_full[r_wr_bank] <= 1'b1;
        r_wr_bank         <= ~r_wr_bank;
      end
      if (w_send_last) begin
        r_full[r_rd_bank] <= 1'b0;
        r_rd_bank         <= ~r_rd_bank;
      end
    end
  end
`else
  assign w_can_write   = (r_state == CAPTURE);
  assign w_pending     = 1'b0;
  assign w_ram_wr_addr = RW'(r_wr_addr);
  assign w_ram_rd_addr = RW'(r_rd_addr);
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= CAPTURE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      CAPTURE:   if (w_frame_done) w_next_state = WAIT_SINK;
      WAIT_SINK: if (i_sink_ready) w_next_state = SEND;
      SEND:      if (w_send_last)  w_next_state = w_pending ? WAIT_SINK : CAPTURE;
      default:   w_next_state = CAPTURE;
    endcase
  end

  // Write address: +HW per channel step; on channel wrap jump to the next
  // spatial position. Only adds, no per-pixel multiply.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_c       <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_pos     <= '0;
      r_wr_addr <= '0;
    end else if (w_accept) begin
      if (w_frame_done) begin
        r_c       <= '0;
        r_col     <= '0;
        r_row     <= '0;
        r_pos     <= '0;
        r_wr_addr <= '0;
      end else if (r_c == CW'(CHANNELS - 1)) begin
        r_c       <= '0;
        r_pos     <= r_pos + 1'b1;
        r_wr_addr <= r_pos + 1'b1;
        if (r_col == XW'(WIDTH - 1)) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end else begin
        r_c       <= r_c + 1'b1;
        r_wr_addr <= r_wr_addr + AW'(HW);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_addr <= '0;
    end else if (r_state == SEND) begin
      r_rd_addr <= w_send_last ? '0 : r_rd_addr + 1'b1;
    end else begin
      r_rd_addr <= '0;
    end
  end

  fc_flatten_ram #(
    .DEPTH (DEPTH),
    .AW    (RW)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_accept),
    .i_wr_addr (w_ram_wr_addr),
    .i_wr_data (i_pix_in),
    .i_rd_en   (r_state == SEND),
    .i_rd_addr (w_ram_rd_addr),
    .o_rd_data (w_ram_rd_data)
  );

  // Two-stage output: RAM read register, then the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ram_valid      <= 1'b0;
      r_ram_last       <= 1'b0;
      r_data_out       <= '0;
      r_data_valid_out <= 1'b0;
      r_out_last       <= 1'b0;
      r_frame_sent     <= 1'b0;
      r_overflow       <= 1'b0;
    end else begin
      r_ram_valid      <= (r_state == SEND);
      r_ram_last       <= w_send_last;
      r_data_out       <= r_ram_valid ? w_ram_rd_data : 8'sd0;
      r_data_valid_out <= r_ram_valid;
      r_out_last       <= r_ram_last;
      r_frame_sent     <= r_out_last;
      if (i_pix_valid_in && !w_can_write) r_overflow <= 1'b1;
    end
  end

  assign o_data_out       = r_data_out;
  assign o_data_valid_out = r_data_valid_out;
  assign o_frame_sent     = r_frame_sent;
  assign o_overflow       = r_overflow;

endmodule
